// File: rtl/instr_sequencer_pkg.sv
// Shared constants and types for the 19-bit CPU instruction sequencer.
// Holds the opcode encodings, the load/ALU selectors and the FSM state type.
package instr_sequencer_pkg;

  localparam int WORD_SIZE = 19;
  localparam int OPCODE_W  = 5;
  localparam int ADDR_W    = 14;

  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  localparam logic [OPCODE_W-1:0] OP_NOP = 5'h00;
  localparam logic [OPCODE_W-1:0] OP_LD  = 5'h01;
  localparam logic [OPCODE_W-1:0] OP_ST  = 5'h02;
  localparam logic [OPCODE_W-1:0] OP_ADD = 5'h03;
  localparam logic [OPCODE_W-1:0] OP_SUB = 5'h04;
  localparam logic [OPCODE_W-1:0] OP_JMP = 5'h05;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 5'h06;
  localparam logic [OPCODE_W-1:0] OP_HLT = 5'h07;

  typedef enum logic {LOAD_IR, LOAD_ACC} load_sel_t;

  typedef enum logic {ALU_ADD, ALU_SUB} alu_op_t;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM_RD,
    MEM_WR,
    ALU_WAIT,
    HALT
  } seq_state_t;

  // Everything outside the defined set is reported as illegal and run as a NOP.
  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    return (op <= OP_HLT);
  endfunction

endpackage

// File: rtl/instr_sequencer_pc_counter.sv
// Program counter register: synchronous reset, parallel load, or increment
// with natural wrap from the top address back to zero.
module pc_counter
  import instr_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VALUE = RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  output logic [ADDR_W-1:0] pc
);

  // A jump and an increment never coincide, but load wins if they ever did.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VALUE;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller: owns the PC, runs the memory
// handshake, strobes IR/ACC loads and sequences ALU, load/store and branches.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VALUE = RESET_PC
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [ADDR_W-1:0]   operand_addr,
  input  logic                mem_ready,
  input  logic                alu_done,
  input  logic                zero_flag,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                load_reg,
  output load_sel_t           load_select,
  output logic                alu_start,
  output alu_op_t             alu_op,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic                illegal_op
);

  seq_state_t        state;
  seq_state_t        next_state;
  logic              pc_inc;
  logic              pc_load;

  pc_counter #(
    .RESET_VALUE(RESET_VALUE)
  ) u_pc (
    .clk       (CLK),
    .rst       (RST),
    .inc       (pc_inc),
    .load      (pc_load),
    .load_value(operand_addr),
    .pc        (pc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    unique case (state)
      FETCH: begin
        if (mem_ready) begin
          pc_inc     = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: next_state = EXEC;
      EXEC: begin
        unique case (opcode)
          OP_LD:          next_state = MEM_RD;
          OP_ST:          next_state = MEM_WR;
          OP_ADD, OP_SUB: next_state = ALU_WAIT;
          OP_HLT:         next_state = HALT;
          OP_JMP: begin
            pc_load    = 1'b1;
            next_state = FETCH;
          end
          OP_JZ: begin
            pc_load    = zero_flag;
            next_state = FETCH;
          end
          default:        next_state = FETCH;
        endcase
      end
      MEM_RD, MEM_WR: begin
        if (mem_ready) next_state = FETCH;
      end
      ALU_WAIT: begin
        if (alu_done) next_state = FETCH;
      end
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  // Outputs are held quiet during a reset cycle so a pending request drops at once.
  always_comb begin
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = pc;
    load_reg    = 1'b0;
    load_select = LOAD_IR;
    alu_start   = 1'b0;
    alu_op      = ALU_ADD;
    halted      = 1'b0;
    illegal_op  = 1'b0;
    if (!RST) begin
      unique case (state)
        FETCH: begin
          mem_rd   = 1'b1;
          load_reg = mem_ready;
        end
        EXEC: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_start = 1'b1;
            alu_op    = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
          end
          illegal_op = !is_legal_op(opcode);
        end
        MEM_RD: begin
          mem_rd   = 1'b1;
          mem_addr = operand_addr;
          if (mem_ready) begin
            load_reg    = 1'b1;
            load_select = LOAD_ACC;
          end
        end
        MEM_WR: begin
          mem_wr   = 1'b1;
          mem_addr = operand_addr;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
